// File: rtl/viterbi_acs_scheduler.sv
// viterbi_acs_scheduler
// Issues the butterfly groups of one trellis step to a shared BMC/ACS array,
// one group per cycle. It also produces the write strobes for new metrics and
// decisions, delayed by the ACS pipeline latency, and it owns the ping-pong
// path-metric bank select, initialisation and normalisation controls.
module viterbi_acs_scheduler #(
   parameter  int NUM_STATES = 64,
   parameter  int NUM_UNITS  = 8,
   parameter  int ACS_LAT    = 2,
   parameter  int SCW        = 16,
   localparam int G          = NUM_STATES / (2 * NUM_UNITS),
   localparam int GW         = (G > 1) ? $clog2(G) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rx_valid,
   input  logic [1:0]     rx_pair,
   input  logic           frame_start,
   output logic           rx_ready,
   output logic [1:0]     acs_rx_pair,
   output logic           grp_valid,
   output logic [GW-1:0]  grp_idx,
   output logic           pm_rd_bank,
   output logic           pm_init,
   output logic           norm_en,
   output logic           wr_en,
   output logic [GW-1:0]  wr_grp_idx,
   input  logic           metric_ovf,
   output logic           sym_done,
   output logic [SCW-1:0] sym_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [GW-1:0] LAST_GRP = GW'(G - 1);

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               ovf_acc;
   logic [ACS_LAT-1:0] vld_pipe;
   logic [GW-1:0]      idx_pipe [ACS_LAT];

   assign accept     = rx_valid & rx_ready;
   assign wr_en      = vld_pipe[ACS_LAT-1];
   assign wr_grp_idx = idx_pipe[ACS_LAT-1];

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: one symbol is IDLE -> RUN (G cycles) -> DRAIN -> DONE.
   always_comb begin
      // NOTE: default assignment first, so no path leaves state_nxt unassigned and infers a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (grp_idx == LAST_GRP) state_nxt = DRAIN;
         DRAIN:   if (wr_en && (wr_grp_idx == LAST_GRP)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      rx_ready  = (state == IDLE);
      grp_valid = (state == RUN);
      sym_done  = (state == DONE);
   end

   // Per-symbol controls: latched at accept and held until DONE updates them.
   always_ff @(posedge clk) begin
      if (rst) begin
         grp_idx     <= '0;
         acs_rx_pair <= '0;
         pm_init     <= 1'b0;
         pm_rd_bank  <= 1'b0;
         norm_en     <= 1'b0;
         sym_cnt     <= '0;
         ovf_acc     <= 1'b0;
      end else begin
         if (accept) begin
            acs_rx_pair <= rx_pair;
            pm_init     <= frame_start;
            ovf_acc     <= 1'b0;
            grp_idx     <= '0;
            if (frame_start) begin
               pm_rd_bank <= 1'b0;
               sym_cnt    <= '0;
               norm_en    <= 1'b0;
            end
         end
         if (grp_valid) grp_idx <= (grp_idx == LAST_GRP) ? '0 : grp_idx + 1'b1;
         // Overflow only counts when it belongs to a real write.
         if (wr_en && metric_ovf) ovf_acc <= 1'b1;
         if (sym_done) begin
            pm_rd_bank <= ~pm_rd_bank;
            sym_cnt    <= sym_cnt + 1'b1;
            pm_init    <= 1'b0;
            norm_en    <= ovf_acc;
         end
      end
   end

   // Write delay line: grp_valid/grp_idx delayed exactly ACS_LAT cycles.
   always_ff @(posedge clk) begin
      // NOTE: the delay line is reset as well, so a reset mid-symbol cannot leave a write in flight.
      if (rst) begin
         vld_pipe <= '0;
         for (int i = 0; i < ACS_LAT; i++) idx_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= grp_valid;
         idx_pipe[0] <= grp_idx;
         for (int i = 1; i < ACS_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
      end
   end

endmodule

// File: tb/tb_viterbi_acs_scheduler.sv
// tb_viterbi_acs_scheduler
// Drives four scheduler configurations (default, ACS_LAT=1, ACS_LAT=4,
// NUM_UNITS=32) with one shared stimulus stream. Each configuration has a
// model that tracks the offset of the current cycle from the accept cycle
// and derives every output from that offset.
module tb_viterbi_acs_scheduler;

   localparam int NCFG = 4;
   localparam int LAT0 = 2;

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic       rx_valid    = 1'b0;
   logic [1:0] rx_pair     = 2'b00;
   logic       frame_start = 1'b0;
   logic       metric_ovf  = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   for (genvar c = 0; c < NCFG; c++) begin : cfg
      localparam int L  = (c == 1) ? 1 : (c == 2) ? 4 : 2;
      localparam int U  = (c == 3) ? 32 : 8;
      localparam int G  = 64 / (2 * U);
      localparam int GW = (G > 1) ? $clog2(G) : 1;

      logic          rx_ready, grp_valid, pm_rd_bank, pm_init, norm_en, wr_en, sym_done;
      logic [1:0]    acs_rx_pair;
      logic [GW-1:0] grp_idx, wr_grp_idx;
      logic [15:0]   sym_cnt;

      viterbi_acs_scheduler #(
         .NUM_STATES(64), .NUM_UNITS(U), .ACS_LAT(L), .SCW(16)
      ) dut (
         .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_pair(rx_pair),
         .frame_start(frame_start), .rx_ready(rx_ready), .acs_rx_pair(acs_rx_pair),
         .grp_valid(grp_valid), .grp_idx(grp_idx), .pm_rd_bank(pm_rd_bank),
         .pm_init(pm_init), .norm_en(norm_en), .wr_en(wr_en), .wr_grp_idx(wr_grp_idx),
         .metric_ovf(metric_ovf), .sym_done(sym_done), .sym_cnt(sym_cnt)
      );

      // Model: busy + d = offset of this cycle from the accept cycle.
      // Offsets 1..G issue groups, L+1..G+L write, G+L+1 is the done cycle.
      bit         busy, m_bank, m_init, m_norm, m_acc, seen, just_rst;
      bit         e_gv, e_wr, e_done;
      int         d, m_cnt;
      logic [1:0] m_pair;

      initial begin
         busy = 0; m_bank = 0; m_init = 0; m_norm = 0; m_acc = 0; seen = 0;
         just_rst = 0; d = 0; m_cnt = 0; m_pair = 2'b00;
         forever begin
            @(posedge clk);
            if (rst) begin
               busy = 0; m_bank = 0; m_init = 0; m_norm = 0; m_acc = 0;
               m_cnt = 0; m_pair = 2'b00; seen = 1; just_rst = 1;
            end else begin
               just_rst = 0;
               if (!busy) begin
                  if (rx_valid) begin
                     busy   = 1;
                     d      = 1;
                     m_pair = rx_pair;
                     m_init = frame_start;
                     m_acc  = 0;
                     if (frame_start) begin
                        m_bank = 0; m_cnt = 0; m_norm = 0;
                     end
                  end
               end else begin
                  if (d >= L + 1 && d <= G + L && metric_ovf) m_acc = 1;
                  if (d == G + L + 1) begin
                     busy   = 0;
                     m_bank = !m_bank;
                     m_cnt  = (m_cnt + 1) % 65536;
                     m_init = 0;
                     m_norm = m_acc;
                  end else begin
                     d++;
                  end
               end
            end
            @(negedge clk);
            if (seen) begin
               e_gv   = busy && d >= 1 && d <= G;
               e_wr   = busy && d >= L + 1 && d <= G + L;
               e_done = busy && d == G + L + 1;
               check($sformatf("c%0d rx_ready", c),    32'(rx_ready),    32'(!busy));
               check($sformatf("c%0d grp_valid", c),   32'(grp_valid),   32'(e_gv));
               check($sformatf("c%0d wr_en", c),       32'(wr_en),       32'(e_wr));
               check($sformatf("c%0d sym_done", c),    32'(sym_done),    32'(e_done));
               check($sformatf("c%0d acs_rx_pair", c), 32'(acs_rx_pair), 32'(m_pair));
               check($sformatf("c%0d pm_rd_bank", c),  32'(pm_rd_bank),  32'(m_bank));
               check($sformatf("c%0d pm_init", c),     32'(pm_init),     32'(m_init));
               check($sformatf("c%0d norm_en", c),     32'(norm_en),     32'(m_norm));
               check($sformatf("c%0d sym_cnt", c),     32'(sym_cnt),     m_cnt);
               if (e_gv) check($sformatf("c%0d grp_idx", c), 32'(grp_idx), d - 1);
               if (e_wr) check($sformatf("c%0d wr_grp_idx", c), 32'(wr_grp_idx), d - 1 - L);
               if (just_rst) begin
                  check($sformatf("c%0d reset grp_idx", c),    32'(grp_idx),    0);
                  check($sformatf("c%0d reset wr_grp_idx", c), 32'(wr_grp_idx), 0);
               end
            end
         end
      end
   end

   // Wait (bounded) at negedges until the default instance is ready.
   task automatic wait_ready();
      int n = 0;
      while (cfg[0].rx_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("rx_ready timeout", 32'(cfg[0].rx_ready), 1);
   endtask

   // Offer one symbol to the default instance for one cycle. Optionally pulse
   // metric_ovf on the write of group ovf_grp, and raise a stray metric_ovf on
   // the accept cycle and the first issue cycle (no write in flight then).
   // Returns in the second cycle after accept.
   task automatic send_sym(input logic [1:0] pair, input bit fs, input int ovf_grp, input bit stray);
      wait_ready();
      rx_valid    = 1'b1;
      rx_pair     = pair;
      frame_start = fs;
      metric_ovf  = stray;
      @(negedge clk);
      rx_valid    = 1'b0;
      frame_start = 1'b0;
      rx_pair     = 2'($urandom);
      @(negedge clk);
      metric_ovf  = 1'b0;
      if (ovf_grp >= 0) begin
         repeat (LAT0 + 1 + ovf_grp - 2) @(negedge clk);
         metric_ovf = 1'b1;
         @(negedge clk);
         metric_ovf = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single symbol after reset.
      send_sym(2'b11, 1'b1, -1, 1'b0);

      // Frame start without rx_valid must be ignored.
      wait_ready();
      frame_start = 1'b1;
      repeat (3) @(negedge clk);
      frame_start = 1'b0;

      // Back-to-back stream of 10 symbols with rx_valid held high.
      wait_ready();
      rx_valid    = 1'b1;
      frame_start = 1'b1;
      rx_pair     = 2'($urandom);
      @(negedge clk);
      frame_start = 1'b0;
      repeat (79) begin
         rx_pair = 2'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b0;
      check("b2b sym_cnt", 32'(cfg[0].sym_cnt), 10);
      check("b2b rx_ready", 32'(cfg[0].rx_ready), 1);

      // Normalisation: overflow on group 2 of symbol N, stray overflow elsewhere.
      send_sym(2'b01, 1'b0, 2, 1'b1);
      send_sym(2'b10, 1'b0, -1, 1'b1);
      check("norm_en after ovf", 32'(cfg[0].norm_en), 1);
      send_sym(2'b00, 1'b0, -1, 1'b0);
      check("norm_en cleared", 32'(cfg[0].norm_en), 0);

      // Mid-frame restart with bank=1 and norm_en=1 pending.
      send_sym(2'b11, 1'b1, -1, 1'b0);
      for (int i = 0; i < 4; i++) send_sym(2'($urandom), 1'b0, (i == 3) ? 1 : -1, 1'b0);
      wait_ready();
      check("pre-restart bank", 32'(cfg[0].pm_rd_bank), 1);
      send_sym(2'b10, 1'b1, -1, 1'b0);
      check("restart pm_rd_bank", 32'(cfg[0].pm_rd_bank), 0);
      check("restart pm_init", 32'(cfg[0].pm_init), 1);
      check("restart norm_en", 32'(cfg[0].norm_en), 0);
      wait_ready();
      check("restart sym_cnt", 32'(cfg[0].sym_cnt), 1);

      // Reset during DRAIN (offset 5 at defaults).
      send_sym(2'b01, 1'b0, -1, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Randomised traffic, including occasional resets.
      repeat (3000) begin
         @(negedge clk);
         rst         = ($urandom_range(0, 199) == 0);
         rx_valid    = 1'($urandom_range(0, 1));
         rx_pair     = 2'($urandom);
         frame_start = ($urandom_range(0, 7) == 0);
         metric_ovf  = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      rst        = 1'b0;
      rx_valid   = 1'b0;
      metric_ovf = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/viterbi_acs_scheduler.md
Name: viterbi_acs_scheduler

Overview:
- Sequences a shared bank of BMC/ACS butterfly units across all trellis states of a rate-1/2 Viterbi decoder (K=7, 64 states).
- Accepts one received symbol pair per handshake and issues the butterfly groups to the units in turn.
- Drives the ping-pong path-metric bank select and the write strobes for new metrics and decisions, delayed to match ACS pipeline latency.
- Sits between the input symbol stream and the BMC/ACS array; the traceback unit consumes its write strobes and sym_done.

Parameters:
- NUM_STATES, 64, trellis states; power of 2.
- NUM_UNITS, 8, parallel butterfly units; power of 2; each covers 2 states.
- ACS_LAT, 2, cycles from grp_valid to ACS results valid; 1 to 4.
- SCW, 16, symbol counter width.
- Derived: G = NUM_STATES/(2*NUM_UNITS) groups per symbol (default 4). GW = max(1, log2(G)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  symbol pair offered
- rx_pair  in  2  received hard-decision pair
- frame_start  in  1  qualifies the accepted symbol as the first of a frame
- rx_ready  out  1  scheduler can accept a symbol
- acs_rx_pair  out  2  latched pair fed to all BMC units
- grp_valid  out  1  group issue strobe to the ACS array
- grp_idx  out  GW  group being issued
- pm_rd_bank  out  1  source path-metric bank; the destination bank is its inverse
- pm_init  out  1  ACS uses initial metrics (state 0 = 0, others = max) instead of reading the source bank
- norm_en  out  1  ACS subtracts the normalisation constant from source metrics
- wr_en  out  1  write new metrics and decisions
- wr_grp_idx  out  GW  group address for the write
- metric_ovf  in  1  some written metric has its MSB set; sampled only when wr_en=1
- sym_done  out  1  one-cycle pulse when a symbol is fully written
- sym_cnt  out  SCW  symbols completed in the current frame

Behaviour:
- States: IDLE, RUN, DRAIN, DONE.
- Reset values (any cycle, including mid-symbol): state=IDLE, rx_ready=1, grp_valid=0, wr_en=0, sym_done=0, grp_idx=0, wr_grp_idx=0, pm_rd_bank=0, pm_init=0, norm_en=0, acs_rx_pair=0, sym_cnt=0. The write pipeline is also cleared.
- rx_ready = 1 only in IDLE. Accept = rx_valid & rx_ready.

IDLE:
- On accept: latch rx_pair into acs_rx_pair. pm_init <= frame_start.
- If frame_start: also pm_rd_bank <= 0, sym_cnt <= 0, norm_en <= 0.
- Go to RUN with grp_idx=0.

RUN:
- grp_valid=1 every cycle. grp_idx counts 0..G-1.
- After issuing G-1, go to DRAIN.

DRAIN:
- Wait until the last write has occurred.
- Write pipeline: wr_en and wr_grp_idx are grp_valid and grp_idx delayed exactly ACS_LAT cycles through a shift register.
- Leave DRAIN on the cycle after wr_en for group G-1; go to DONE.

DONE (one cycle):
- sym_done=1. pm_rd_bank toggles. sym_cnt increments, wrapping at 2^SCW.
- pm_init clears.
- norm_en <= OR of metric_ovf over all G writes of this symbol. The accumulator clears at accept.
- Return to IDLE.

Timing and overlap rules:
- acs_rx_pair, pm_rd_bank, pm_init and norm_en are stable from accept through DONE.
- No overlap between symbols: a new symbol is accepted no earlier than the cycle after DONE.
- Symbol period = 1 (accept) + G + ACS_LAT + 1 = 8 cycles at defaults, with rx_valid held high.

Other boundary conditions:
- frame_start when rx_valid=0: ignored.
- metric_ovf when wr_en=0: ignored.
- G=1: RUN lasts one cycle.
- rx_pair may change while rx_ready=0 with no effect.

Test Plan:
- Reset then a single symbol: rst for 2 cycles. Then rx_valid=1, rx_pair=2'b11, frame_start=1 for one cycle. Required: pm_init=1; grp_idx 0,1,2,3 on consecutive cycles with grp_valid=1; wr_en high 2 cycles after each; sym_done 1 cycle after the last write; pm_rd_bank 0→1; sym_cnt=1.
- Back-to-back stream: rx_valid held 1 for 10 symbols. Required: accepts exactly every 8 cycles; pm_rd_bank alternates; pm_init only on the first symbol; sym_cnt=10; no grp_valid overlap between symbols.
- Normalisation: pulse metric_ovf=1 coincident with the wr_en of group 2 in symbol N. Required: norm_en=1 throughout symbol N+1. norm_en=0 in symbol N+2 if no overflow occurs in N+1. metric_ovf while wr_en=0 has no effect.
- Mid-frame restart: frame_start=1 on symbol 5 when pm_rd_bank=1. Required: pm_rd_bank forced to 0, sym_cnt restarts so DONE yields 1, norm_en cleared, pm_init=1.
- Reset mid-operation: assert rst during DRAIN. Required: next cycle all outputs at reset values, no wr_en or sym_done afterwards, rx_ready=1.
- Parameter sweep: ACS_LAT=1 and 4, NUM_UNITS=32 (G=1). Required: write offset equals ACS_LAT; symbol period = 3 + G + ACS_LAT - 1... checked as 1+G+ACS_LAT+1 cycles.
